// File: rtl/sample_player_pkg.sv
// Shared types and constants for the sample player: FSM encoding, status-word
// layout and half-word phase values.
package sample_player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_PLAY    = 2'd2,
    ST_STARVED = 2'd3
  } state_t;

  localparam int STAT_OVF_BIT   = 31;
  localparam int STAT_UNF_BIT   = 30;
  localparam int STAT_STATE_LSB = 28;
  localparam int STAT_FILL_LSB  = 0;

  localparam logic PHASE_A = 1'b0;
  localparam logic PHASE_B = 1'b1;

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data and an exact occupancy count.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (fill == (AW+1)'(DEPTH));
  assign empty   = (fill == '0);
  assign do_push = push & ~full & ~rst;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fill <= fill + (AW+1)'(1);
        2'b01:   fill <= fill - (AW+1)'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/sample_player.sv
// Buffers packed 16-bit sample pairs from the host pipe and plays them out at a
// programmable rate, reporting sticky overrun/underrun flags in a status word.
//
// state      | meaning
// ST_IDLE    | just out of reset, moves to prefill next cycle
// ST_PREFILL | waiting for PREFILL buffered words and a nonzero rate
// ST_PLAY    | emitting one half-word per tick, A then B
// ST_STARVED | underrun emitted, returns to prefill next cycle
module sample_player
  import sample_player_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int PREFILL = 512
) (
  input  logic        okClk,
  input  logic        mst_reset,
  input  logic        ep_write,
  input  logic [31:0] ep_dataout,
  input  logic [31:0] rate_div,
  input  logic        ep_read,
  output logic [31:0] ep_datain,
  output logic [15:0] sample_out,
  output logic        sample_stb,
  output logic        playing
);
  localparam int FW = $clog2(DEPTH) + 1;

  state_t        state, state_nxt;
  logic          phase, phase_nxt;
  logic [31:0]   tick_cnt, tick_cnt_nxt;
  logic          tick, pop, starve, emit;
  logic [15:0]   emit_val;
  logic [15:0]   held_b;
  logic          ovf, unf, ovf_set;
  logic [31:0]   status;
  logic          push, fifo_full, fifo_empty;
  logic [31:0]   fifo_rdata;
  logic [FW-1:0] fill;

  assign push    = ep_write & ~fifo_full;
  assign ovf_set = ep_write & fifo_full;
  assign playing = (state == ST_PLAY);

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (okClk),
    .rst   (mst_reset),
    .push  (push),
    .pop   (pop),
    .wdata (ep_dataout),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  always_ff @(posedge okClk) begin
    if (mst_reset) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    tick_cnt_nxt = tick_cnt;
    pop          = 1'b0;
    starve       = 1'b0;
    emit         = 1'b0;
    emit_val     = '0;
    // Compare with >= so a lowered rate wraps at once instead of running to 2^32.
    tick = (state == ST_PLAY) && (rate_div != 32'd0) && (tick_cnt >= rate_div - 32'd1);

    if (state != ST_PLAY || rate_div == 32'd0) tick_cnt_nxt = '0;
    else if (tick)                             tick_cnt_nxt = '0;
    else                                       tick_cnt_nxt = tick_cnt + 32'd1;

    case (state)
      ST_IDLE:    state_nxt = ST_PREFILL;
      ST_PREFILL: begin
        if (fill >= FW'(PREFILL) && rate_div != 32'd0) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (tick) begin
          emit = 1'b1;
          if (phase == PHASE_B) begin
            emit_val  = held_b;
            phase_nxt = PHASE_A;
          end else if (fifo_empty) begin
            starve    = 1'b1;
            state_nxt = ST_STARVED;
          end else begin
            pop       = 1'b1;
            emit_val  = fifo_rdata[15:0];
            phase_nxt = PHASE_B;
          end
        end
      end
      ST_STARVED: begin
        state_nxt = ST_PREFILL;
        phase_nxt = PHASE_A;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    status = '0;
    status[STAT_OVF_BIT]          = ovf;
    status[STAT_UNF_BIT]          = unf;
    status[STAT_STATE_LSB +: 2]   = state;
    status[STAT_FILL_LSB +: 16]   = sat16(32'(fill));
  end

  always_ff @(posedge okClk) begin
    if (mst_reset) begin
      tick_cnt   <= '0;
      phase      <= PHASE_A;
      held_b     <= '0;
      sample_out <= '0;
      sample_stb <= 1'b0;
      ovf        <= 1'b0;
      unf        <= 1'b0;
      ep_datain  <= '0;
    end else begin
      tick_cnt   <= tick_cnt_nxt;
      phase      <= phase_nxt;
      sample_stb <= emit;
      if (emit) sample_out <= emit_val;
      if (pop)  held_b     <= fifo_rdata[31:16];
      // A set in the same cycle as a read-clear wins.
      ovf       <= ovf_set | (ovf & ~ep_read);
      unf       <= starve  | (unf & ~ep_read);
      ep_datain <= status;
    end
  end

endmodule
